// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the
// shared single-port memory. Member names keep the arbiter-side i_/o_ view.
//
// Handshake contract: a requester raises *_valid with stable fields and holds
// them until the cycle *_ready is 1; that cycle is the transfer. The same rule
// holds for o_mem_req_valid / i_mem_req_ready. Response valids are one-cycle
// pulses with no back-pressure.
interface mem_arbiter_if;
    logic        i_ireq_valid;
    logic [31:0] i_ireq_addr;
    logic        o_ireq_ready;
    logic        o_iresp_valid;
    logic [31:0] o_iresp_rdata;

    logic        i_dreq_valid;
    logic [31:0] i_dreq_addr;
    logic        i_dreq_wen;
    logic [31:0] i_dreq_wdata;
    logic [3:0]  i_dreq_mask;
    logic        o_dreq_ready;
    logic        o_dresp_valid;
    logic [31:0] o_dresp_rdata;

    logic        o_mem_req_valid;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_req_ready;
    logic        i_mem_resp_valid;
    logic [31:0] i_mem_rdata;

    // Arbiter side
    modport slave (
        input  i_ireq_valid, i_ireq_addr,
        output o_ireq_ready, o_iresp_valid, o_iresp_rdata,
        input  i_dreq_valid, i_dreq_addr, i_dreq_wen, i_dreq_wdata, i_dreq_mask,
        output o_dreq_ready, o_dresp_valid, o_dresp_rdata,
        output o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
        input  i_mem_req_ready, i_mem_resp_valid, i_mem_rdata
    );

    // Environment side (requesters plus memory)
    modport master (
        output i_ireq_valid, i_ireq_addr,
        input  o_ireq_ready, o_iresp_valid, o_iresp_rdata,
        output i_dreq_valid, i_dreq_addr, i_dreq_wen, i_dreq_wdata, i_dreq_mask,
        input  o_dreq_ready, o_dresp_valid, o_dresp_rdata,
        input  o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
        output i_mem_req_ready, i_mem_resp_valid, i_mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a shared memory with one outstanding
// transaction. Data requests win unless the fetch side has already waited
// through STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mem_arbiter_if.slave  bus,
    output logic [1:0]    o_dbg_state
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_starve;
    logic [31:0]   r_addr;
    logic          r_wen;
    logic [31:0]   r_wdata;
    logic [3:0]    r_mask;
    logic          r_owner_d;   // 1 = data requester owns the transaction

    logic w_idle;
    logic w_starved;
    logic w_grant_i;
    logic w_grant_d;

    // Grants are only offered out of reset so every output stays 0 while reset is held.
    assign w_idle      = (r_state == ST_IDLE) && i_rst_n;
    assign w_starved   = (r_starve == LIMIT) && bus.i_ireq_valid;
    assign w_grant_d   = w_idle && bus.i_dreq_valid && !w_starved;
    assign w_grant_i   = w_idle && bus.i_ireq_valid && !w_grant_d;
    assign o_dbg_state = r_state;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Latch the winning request; word-align the address on capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr    <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_mask    <= '0;
            r_owner_d <= 1'b0;
        end else if (w_grant_d) begin
            r_addr    <= {bus.i_dreq_addr[31:2], 2'b00};
            r_wen     <= bus.i_dreq_wen;
            r_wdata   <= bus.i_dreq_wdata;
            r_mask    <= bus.i_dreq_mask;
            r_owner_d <= 1'b1;
        end else if (w_grant_i) begin
            r_addr    <= {bus.i_ireq_addr[31:2], 2'b00};
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_mask    <= 4'b1111;
            r_owner_d <= 1'b0;
        end
    end

    // Starvation counter: counts data grants taken while a fetch was waiting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (w_grant_i) begin
            r_starve <= '0;
        end else if (w_grant_d) begin
            if (!bus.i_ireq_valid)      r_starve <= '0;
            else if (r_starve != LIMIT) r_starve <= r_starve + CW'(1);
        end
    end

    // Next-state and all bus outputs.
    always_comb begin
        w_next              = r_state;
        bus.o_ireq_ready    = w_grant_i;
        bus.o_dreq_ready    = w_grant_d;
        bus.o_iresp_valid   = 1'b0;
        bus.o_iresp_rdata   = '0;
        bus.o_dresp_valid   = 1'b0;
        bus.o_dresp_rdata   = '0;
        bus.o_mem_req_valid = 1'b0;
        bus.o_mem_addr      = '0;
        bus.o_mem_wen       = 1'b0;
        bus.o_mem_wdata     = '0;
        bus.o_mem_mask      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_i || w_grant_d) w_next = ST_REQ;
            end
            ST_REQ: begin
                bus.o_mem_req_valid = 1'b1;
                bus.o_mem_addr      = r_addr;
                bus.o_mem_wen       = r_wen;
                bus.o_mem_wdata     = r_wdata;
                bus.o_mem_mask      = r_mask;
                if (bus.i_mem_req_ready) begin
                    // Stores complete on acceptance; nothing comes back from memory.
                    if (r_wen) begin
                        bus.o_dresp_valid = 1'b1;
                        w_next            = ST_IDLE;
                    end else begin
                        w_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.i_mem_resp_valid) begin
                    if (r_owner_d) begin
                        bus.o_dresp_valid = 1'b1;
                        bus.o_dresp_rdata = bus.i_mem_rdata;
                    end else begin
                        bus.o_iresp_valid = 1'b1;
                        bus.o_iresp_rdata = bus.i_mem_rdata;
                    end
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } dreq_t;

    typedef struct packed {
        logic        owner_d;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } memx_t;

    typedef struct packed {
        logic        owner_d;
        logic [31:0] rdata;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- stimulus / scoreboard state ----------------
    logic [31:0] iq[$];
    dreq_t       dq[$];
    memx_t       mem_exp_q[$];
    resp_t       resp_exp_q[$];
    logic [31:0] mem_img[logic [31:0]];

    int n_checks = 0;
    int n_pass   = 0;
    int p_igap = 100, p_dgap = 100, p_rdy = 100, p_rsp = 100;

    int          m_phase = 0;   // 0 free, 1 request outstanding, 2 awaiting read data
    int          m_wait  = 0;   // data grants taken while a fetch waited
    logic        m_store = 1'b0;
    logic        m_owner_d = 1'b0;
    logic        due_i = 1'b0, due_d = 1'b0;
    logic        ifire = 1'b0, dfire = 1'b0;
    logic [31:0] cur_addr = '0;
    string       glog = "";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    // ---------------- reference model (negedge) ----------------
    always @(negedge clk) begin
        logic        ei, ed;
        logic [31:0] al;
        due_i = 1'b0;
        due_d = 1'b0;
        if (!rst_n) begin
            m_phase = 0;
            m_wait  = 0;
            mem_exp_q.delete();
            resp_exp_q.delete();
            ifire = 1'b0;
            dfire = 1'b0;
            chk("rst_outputs",
                {bus.o_ireq_ready, bus.o_dreq_ready, bus.o_iresp_valid, bus.o_dresp_valid,
                 bus.o_mem_req_valid, bus.o_mem_wen, |bus.o_mem_addr, |bus.o_mem_wdata,
                 |bus.o_mem_mask, |bus.o_iresp_rdata, |bus.o_dresp_rdata}, 64'd0);
            chk("rst_dbg_state", dbg_state, 64'd0);
        end else begin
            ei = 1'b0;
            ed = 1'b0;
            chk("mem_req_valid", bus.o_mem_req_valid, m_phase == 1);
            if (m_phase == 0) begin
                if (bus.i_dreq_valid && !(bus.i_ireq_valid && m_wait == STARVE_LIMIT)) ed = 1'b1;
                else if (bus.i_ireq_valid) ei = 1'b1;
            end
            chk("ireq_ready", bus.o_ireq_ready, ei);
            chk("dreq_ready", bus.o_dreq_ready, ed);
            case (m_phase)
                0: begin
                    if (ed) begin
                        al = {bus.i_dreq_addr[31:2], 2'b00};
                        mem_exp_q.push_back(memx_t'{1'b1, al, bus.i_dreq_wen, bus.i_dreq_wdata, bus.i_dreq_mask});
                        resp_exp_q.push_back(resp_t'{1'b1, bus.i_dreq_wen ? 32'h0 : rd_data(al)});
                        m_wait    = !bus.i_ireq_valid ? 0 : (m_wait < STARVE_LIMIT ? m_wait + 1 : STARVE_LIMIT);
                        m_store   = bus.i_dreq_wen;
                        m_owner_d = 1'b1;
                        cur_addr  = al;
                        dfire     = 1'b1;
                        m_phase   = 1;
                        glog      = {glog, "D"};
                    end else if (ei) begin
                        al = {bus.i_ireq_addr[31:2], 2'b00};
                        mem_exp_q.push_back(memx_t'{1'b0, al, 1'b0, 32'h0, 4'hF});
                        resp_exp_q.push_back(resp_t'{1'b0, rd_data(al)});
                        m_wait    = 0;
                        m_store   = 1'b0;
                        m_owner_d = 1'b0;
                        cur_addr  = al;
                        ifire     = 1'b1;
                        m_phase   = 1;
                        glog      = {glog, "I"};
                    end
                end
                1: begin
                    if (bus.i_mem_req_ready) begin
                        if (m_store) begin
                            due_d   = 1'b1;
                            m_phase = 0;
                        end else begin
                            m_phase = 2;
                        end
                    end
                end
                default: begin
                    if (bus.i_mem_resp_valid) begin
                        if (m_owner_d) due_d = 1'b1;
                        else           due_i = 1'b1;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        memx_t x;
        resp_t r;
        #1;
        if (rst_n) begin
            if (bus.o_mem_req_valid) begin
                if (mem_exp_q.size() == 0) begin
                    chk("mem_req_unexpected", bus.o_mem_req_valid, 64'd0);
                end else begin
                    x = mem_exp_q[0];
                    chk("mem_addr", bus.o_mem_addr, x.addr);
                    chk("mem_wen", bus.o_mem_wen, x.wen);
                    chk("mem_mask", bus.o_mem_mask, x.mask);
                    if (x.wen) chk("mem_wdata", bus.o_mem_wdata, x.wdata);
                    if (bus.i_mem_req_ready) void'(mem_exp_q.pop_front());
                end
            end
            chk("iresp_valid", bus.o_iresp_valid, due_i);
            chk("dresp_valid", bus.o_dresp_valid, due_d);
            if (bus.o_iresp_valid || bus.o_dresp_valid) begin
                if (resp_exp_q.size() == 0) begin
                    chk("resp_unexpected", bus.o_iresp_valid | bus.o_dresp_valid, 64'd0);
                end else begin
                    r = resp_exp_q.pop_front();
                    chk("resp_owner", bus.o_dresp_valid, r.owner_d);
                    chk("resp_both", bus.o_iresp_valid & bus.o_dresp_valid, 64'd0);
                    chk("resp_rdata", r.owner_d ? bus.o_dresp_rdata : bus.o_iresp_rdata, r.rdata);
                end
            end
        end
    end

    // ---------------- drivers: requesters and memory ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ifire) begin
                void'(iq.pop_front());
                ifire = 1'b0;
                bus.i_ireq_valid = 1'b0;
            end
            if (dfire) begin
                void'(dq.pop_front());
                dfire = 1'b0;
                bus.i_dreq_valid = 1'b0;
            end
            if (!bus.i_ireq_valid && iq.size() > 0 && $urandom_range(0, 99) < p_igap) begin
                bus.i_ireq_valid = 1'b1;
                bus.i_ireq_addr  = iq[0];
            end
            if (!bus.i_dreq_valid && dq.size() > 0 && $urandom_range(0, 99) < p_dgap) begin
                bus.i_dreq_valid = 1'b1;
                bus.i_dreq_addr  = dq[0].addr;
                bus.i_dreq_wen   = dq[0].wen;
                bus.i_dreq_wdata = dq[0].wdata;
                bus.i_dreq_mask  = dq[0].mask;
            end
            bus.i_mem_req_ready  = ($urandom_range(0, 99) < p_rdy);
            bus.i_mem_resp_valid = ($urandom_range(0, 99) < p_rsp);
            bus.i_mem_rdata      = rd_data(cur_addr);
        end
    end

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || m_phase != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        #2;
        chk(name, n < budget, 64'd1);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        bus.i_ireq_valid = 1'b0; bus.i_ireq_addr = '0;
        bus.i_dreq_valid = 1'b0; bus.i_dreq_addr = '0; bus.i_dreq_wen = 1'b0;
        bus.i_dreq_wdata = '0;   bus.i_dreq_mask = '0;
        bus.i_mem_req_ready = 1'b0; bus.i_mem_resp_valid = 1'b0; bus.i_mem_rdata = '0;

        repeat (3) @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fetch with immediate memory: response on the third cycle.
        mem_img[32'h0000_0104] = 32'h0010_0073;
        iq.push_back(32'h0000_0104);
        drain("fetch_drain", 50);

        // Store with unaligned address.
        dq.push_back(dreq_t'{32'h0000_2003, 1'b1, 32'hAB00_0000, 4'b1000});
        drain("store_drain", 50);

        // Simultaneous fetch and load: data first.
        glog = "";
        iq.push_back(32'h0000_0200);
        dq.push_back(dreq_t'{32'h0000_0300, 1'b0, 32'h0, 4'hF});
        drain("simul_drain", 50);
        chk_str("simul_order", glog, "DI");

        // Continuous pressure from both sides.
        glog = "";
        for (int i = 0; i < 4; i++) iq.push_back(32'h0000_1000 + 32'(i * 4));
        for (int i = 0; i < 16; i++) dq.push_back(dreq_t'{32'h0000_4000 + 32'(i * 4), 1'b0, 32'h0, 4'hF});
        drain("starve_drain", 400);
        chk_str("starve_order", glog, "DDDDIDDDDIDDDDIDDDDI");

        // Memory stalls for several cycles.
        p_rdy = 0;
        dq.push_back(dreq_t'{32'h0000_5006, 1'b1, 32'h1234_5678, 4'b1100});
        repeat (7) @(negedge clk);
        #2 chk("stall_req_held", bus.o_mem_req_valid, 64'd1);
        p_rdy = 100;
        drain("stall_drain", 50);

        // Random traffic with random handshake delays.
        p_igap = 60; p_dgap = 50; p_rdy = 55; p_rsp = 45;
        for (int i = 0; i < 60; i++) begin
            iq.push_back($urandom);
            dq.push_back(dreq_t'{$urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15))});
        end
        drain("random_drain", 5000);

        // Reset while waiting for read data; a late response must be ignored.
        p_igap = 100; p_dgap = 100; p_rdy = 100; p_rsp = 0;
        dq.push_back(dreq_t'{32'h0000_6000, 1'b0, 32'h0, 4'hF});
        begin
            int n = 0;
            while (m_phase != 2 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("reach_resp", n < 50, 64'd1);
        end
        @(posedge clk); #3 rst_n = 1'b0;
        p_rsp = 100;
        repeat (2) @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("post_rst_state", dbg_state, 64'd0);
        chk("post_rst_no_resp", {bus.o_iresp_valid, bus.o_dresp_valid, bus.o_mem_req_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
